// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle for the round-robin Wishbone arbiter: NIN upstream masters on
// the i_s*/o_s* side, one downstream master port on the o_m*/i_m* side.
// "slave" is the arbiter's own view; "master" is the view of the
// surrounding logic that drives the upstream requests and models the
// downstream slave.
interface wb_rr_arbiter_if #(
    parameter int NIN = 4,
    parameter int AW  = 26,
    parameter int DW  = 32
);
    // upstream requesters
    logic [NIN-1:0]        i_scyc;
    logic [NIN-1:0]        i_sstb;
    logic [NIN-1:0]        i_swe;
    logic [NIN*AW-1:0]     i_saddr;
    logic [NIN*DW-1:0]     i_sdata;
    logic [NIN*DW/8-1:0]   i_ssel;
    logic [NIN-1:0]        o_sstall;
    logic [NIN-1:0]        o_sack;
    logic [NIN-1:0]        o_serr;
    logic [DW-1:0]         o_sdata;
    // downstream master port
    logic                  o_mcyc;
    logic                  o_mstb;
    logic                  o_mwe;
    logic [AW-1:0]         o_maddr;
    logic [DW-1:0]         o_mdata;
    logic [DW/8-1:0]       o_msel;
    logic                  i_mstall;
    logic                  i_mack;
    logic                  i_merr;
    logic [DW-1:0]         i_mdata;
    // current owner, one-hot
    logic [NIN-1:0]        o_grant;

    modport slave (
        input  i_scyc, i_sstb, i_swe, i_saddr, i_sdata, i_ssel,
        output o_sstall, o_sack, o_serr, o_sdata,
        output o_mcyc, o_mstb, o_mwe, o_maddr, o_mdata, o_msel,
        input  i_mstall, i_mack, i_merr, i_mdata,
        output o_grant
    );

    modport master (
        output i_scyc, i_sstb, i_swe, i_saddr, i_sdata, i_ssel,
        input  o_sstall, o_sack, o_serr, o_sdata,
        input  o_mcyc, o_mstb, o_mwe, o_maddr, o_mdata, o_msel,
        output i_mstall, i_mack, i_merr, i_mdata,
        input  o_grant
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin pipelined-Wishbone arbiter. The winner keeps the downstream
// port for its whole CYC; outstanding requests are counted so ACK/ERR are
// routed only to the owner, and a hung cycle can be ended with a bus error
// after TIMEOUT silent cycles (TIMEOUT=0 disables the timer).
module wb_rr_arbiter #(
    parameter int NIN     = 4,
    parameter int AW      = 26,
    parameter int DW      = 32,
    parameter int LGOUT   = 4,
    parameter int TIMEOUT = 0
) (
    input  logic           i_clk,
    input  logic           i_reset,
    wb_rr_arbiter_if.slave bus
);
    localparam int LW = (NIN > 1) ? $clog2(NIN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1) + 2;

    localparam logic             TMO_EN     = (TIMEOUT > 0);
    localparam logic [TW-1:0]    TMO_VAL    = TW'(TIMEOUT);
    localparam logic [TW-1:0]    TIMER_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0]    TIMER_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [LGOUT-1:0] OUT_MAX    = {LGOUT{1'b1}};
    localparam logic [LGOUT-1:0] OUT_ZERO   = {LGOUT{1'b0}};
    localparam logic [LGOUT-1:0] OUT_ONE    = {{(LGOUT-1){1'b0}}, 1'b1};
    localparam logic [NIN-1:0]   GRANT_ONE  = {{(NIN-1){1'b0}}, 1'b1};
    localparam logic [NIN-1:0]   ALL_ONES   = {NIN{1'b1}};
    localparam logic [NIN-1:0]   ALL_ZEROS  = {NIN{1'b0}};
    localparam logic [LW-1:0]    LAST_INIT  = LW'(NIN - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWNED   = 2'd1,
        ST_ERRWAIT = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [LW-1:0]     owner_r, owner_s;
    logic [LW-1:0]     last_r, last_s;
    logic [LGOUT-1:0]  out_r, out_s;
    logic [TW-1:0]     timer_r, timer_s;
    logic [NIN-1:0]    grant_r, grant_s;

    logic              own_cyc_s;
    logic              own_stb_s;
    logic              full_s;
    logic              ack_ok_s;
    logic              err_ok_s;
    logic              tmo_s;
    logic              mcyc_s;
    logic              mstb_s;
    logic [NIN-1:0]    sstall_s;
    logic [NIN-1:0]    sack_s;
    logic [NIN-1:0]    serr_s;
    logic [LW:0]       pick_s;

    // Round-robin search: first requester after 'last' (wrapping); MSB = found.
    function automatic logic [LW:0] rr_pick(input logic [NIN-1:0] req,
                                            input logic [LW-1:0]  last);
        logic [LW:0] res;
        int          idx;
        res = {(LW+1){1'b0}};
        // walk from the farthest slot down so the nearest hit is kept
        for (int i = NIN; i >= 1; i--) begin
            idx = (int'(last) + i) % NIN;
            if (req[idx]) begin
                res = {1'b1, LW'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign own_cyc_s = bus.i_scyc[owner_r];
    assign own_stb_s = bus.i_sstb[owner_r];
    assign full_s    = (out_r == OUT_MAX);
    assign ack_ok_s  = bus.i_mack && (out_r != OUT_ZERO);
    assign err_ok_s  = bus.i_merr && (out_r != OUT_ZERO);
    assign tmo_s     = TMO_EN && (timer_r == TMO_VAL);
    assign pick_s    = rr_pick(bus.i_scyc & bus.i_sstb, last_r);

    // Bus handshake outputs for the current state and owner.
    always_comb begin
        mcyc_s   = 1'b0;
        mstb_s   = 1'b0;
        sstall_s = ALL_ONES;
        sack_s   = ALL_ZEROS;
        serr_s   = ALL_ZEROS;
        case (state_r)
            ST_OWNED: begin
                mcyc_s            = own_cyc_s;
                mstb_s            = own_cyc_s && own_stb_s && !full_s;
                sstall_s[owner_r] = bus.i_mstall || full_s;
                // an error (bus or timeout) swallows a coincident ACK
                if (err_ok_s || tmo_s) begin
                    serr_s[owner_r] = 1'b1;
                end else if (ack_ok_s) begin
                    sack_s[owner_r] = 1'b1;
                end else begin
                    sack_s = ALL_ZEROS;
                end
            end
            ST_IDLE, ST_ERRWAIT: begin
                mcyc_s = 1'b0;
            end
            default: begin
                mcyc_s = 1'b0;
            end
        endcase
    end

    // Next-state: arbitration, release, error handling and counters.
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        last_s  = last_r;
        out_s   = out_r;
        timer_s = timer_r;
        grant_s = grant_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_s[LW]) begin
                    owner_s = pick_s[LW-1:0];
                    last_s  = pick_s[LW-1:0];
                    grant_s = GRANT_ONE << pick_s[LW-1:0];
                    out_s   = OUT_ZERO;
                    timer_s = TIMER_ZERO;
                    state_s = ST_OWNED;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_OWNED: begin
                if (!own_cyc_s) begin
                    // release (also aborts anything still outstanding)
                    state_s = ST_IDLE;
                    grant_s = ALL_ZEROS;
                    out_s   = OUT_ZERO;
                    timer_s = TIMER_ZERO;
                end else if (err_ok_s || tmo_s) begin
                    state_s = ST_ERRWAIT;
                    out_s   = OUT_ZERO;
                    timer_s = TIMER_ZERO;
                end else begin
                    case ({mstb_s && !bus.i_mstall, ack_ok_s})
                        2'b10:   out_s = out_r + OUT_ONE;
                        2'b01:   out_s = out_r - OUT_ONE;
                        default: out_s = out_r;
                    endcase
                    if (TMO_EN && (out_r != OUT_ZERO) && !bus.i_mack && !bus.i_merr) begin
                        timer_s = timer_r + TIMER_ONE;
                    end else begin
                        timer_s = TIMER_ZERO;
                    end
                end
            end
            ST_ERRWAIT: begin
                if (!own_cyc_s) begin
                    state_s = ST_IDLE;
                    grant_s = ALL_ZEROS;
                end else begin
                    state_s = ST_ERRWAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = ALL_ZEROS;
                out_s   = OUT_ZERO;
                timer_s = TIMER_ZERO;
            end
        endcase
    end

    // State, owner, pointer and counter registers with async reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
            owner_r <= {LW{1'b0}};
            last_r  <= LAST_INIT;
            out_r   <= OUT_ZERO;
            timer_r <= TIMER_ZERO;
            grant_r <= ALL_ZEROS;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            last_r  <= last_s;
            out_r   <= out_s;
            timer_r <= timer_s;
            grant_r <= grant_s;
        end
    end

    assign bus.o_mcyc   = mcyc_s;
    assign bus.o_mstb   = mstb_s;
    assign bus.o_mwe    = bus.i_swe[owner_r];
    assign bus.o_maddr  = bus.i_saddr[owner_r*AW +: AW];
    assign bus.o_mdata  = bus.i_sdata[owner_r*DW +: DW];
    assign bus.o_msel   = bus.i_ssel[owner_r*(DW/8) +: (DW/8)];
    assign bus.o_sstall = sstall_s;
    assign bus.o_sack   = sack_s;
    assign bus.o_serr   = serr_s;
    assign bus.o_sdata  = bus.i_mdata;
    assign bus.o_grant  = grant_r;
endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone (pipelined) arbiter that shares one downstream WB master port between NIN upstream bus masters.
- Typical use: merging several bridge read/write channels, or several bridges, onto one WB slave fabric.
- Grant is held for a whole WB cycle (CYC high).
- Tracks outstanding requests per grant, routes ACK/ERR only to the current owner, and can terminate hung cycles with a bus-error timeout.

Parameters:
NIN, 4, number of upstream requesters (2..8)
AW, 26, WB word-address width
DW, 32, WB data width
LGOUT, 4, width of outstanding-request counter; max outstanding = 2^LGOUT-1
TIMEOUT, 0, cycles with outstanding>0 and no ACK/ERR before forced error; 0 disables

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_scyc  in  NIN  per-requester CYC
i_sstb  in  NIN  per-requester STB
i_swe  in  NIN  per-requester WE
i_saddr  in  NIN*AW  per-requester address, requester k at [k*AW +: AW]
i_sdata  in  NIN*DW  per-requester write data
i_ssel  in  NIN*DW/8  per-requester byte select
o_sstall  out  NIN  per-requester STALL
o_sack  out  NIN  per-requester ACK
o_serr  out  NIN  per-requester ERR
o_sdata  out  DW  read data, broadcast (equals i_mdata)
o_mcyc, o_mstb, o_mwe  out  1 each  downstream CYC/STB/WE
o_maddr  out  AW  downstream address
o_mdata  out  DW  downstream write data
o_msel  out  DW/8  downstream byte select
i_mstall, i_mack, i_merr  in  1 each  downstream STALL/ACK/ERR
i_mdata  in  DW  downstream read data
o_grant  out  NIN  one-hot current owner, 0 when idle

Behaviour:
- Reset (asynchronous, i_reset=1):
  - o_grant=0; state IDLE; outstanding=0; timer=0.
  - Round-robin pointer last=NIN-1, so requester 0 has first priority.
  - o_mcyc=o_mstb=0, o_sack=o_serr=0, o_sstall=all-ones.
- States: IDLE, OWNED, ERRWAIT.
- IDLE:
  - Candidates are the requesters k with i_scyc[k]&i_sstb[k].
  - Pick the first candidate searching last+1, last+2, ... modulo NIN.
  - On the clock edge: o_grant=onehot(k), last=k, go to OWNED.
  - No candidates: stay in IDLE.
  - o_mcyc=0 in IDLE; every o_sstall bit is 1.
  - Latency: request in cycle n gives o_mstb in cycle n+1.
- OWNED, owner g:
  - o_mcyc = i_scyc[g].
  - o_mstb = i_sstb[g] & i_scyc[g] & !full, where full = (outstanding == 2^LGOUT-1).
  - o_mwe, o_maddr, o_mdata, o_msel are muxed combinationally from requester g.
  - o_sstall[g] = i_mstall | full. Every other o_sstall bit is 1.
  - o_sack[g] = i_mack & (outstanding>0). ACKs arriving with outstanding==0 are dropped.
- Outstanding counter:
  - +1 on o_mstb&!i_mstall; -1 on i_mack.
  - Accept and ACK in the same cycle: count unchanged.
  - The count never wraps.
- Release:
  - When i_scyc[g]=0 at a clock edge: go to IDLE, outstanding=0, timer=0, o_grant=0.
  - This also applies with outstanding>0 (abort); late ACKs after the abort are dropped.
  - Arbitration runs in the next IDLE cycle, so there is at least one dead cycle between owners.
- Error:
  - i_merr in OWNED: o_serr[g]=1 combinationally (only when outstanding>0).
  - At the edge: outstanding=0, go to ERRWAIT.
- Timeout (TIMEOUT>0):
  - Timer increments each cycle with outstanding>0 and !i_mack & !i_merr; it clears otherwise.
  - Timer==TIMEOUT: assert o_serr[g] for exactly one cycle, then go to ERRWAIT.
  - The timeout error does not drive anything downstream.
- ERRWAIT:
  - o_mcyc=0; o_sstall[g]=1; all ACK/ERR dropped.
  - Stay until i_scyc[g]=0, then go to IDLE.
- Simultaneous events:
  - i_merr and i_mack together: ERR wins and no ACK is forwarded.
  - Owner dropping CYC in the same cycle as i_merr: go straight to IDLE.
- o_sdata = i_mdata at all times.

Test Plan:
- Reset, then requesters 0 and 2 assert CYC/STB at cycle 1 -> o_grant=0001 at cycle 2. Requester 0 does 1 write, ACK, drops CYC -> one IDLE cycle, then o_grant=0100.
- All 4 requesters hold continuous single-beat cycles -> grant order 0,1,2,3,0,... with no requester starved; each grant separated by exactly one IDLE cycle.
- LGOUT=2, owner issues 5 pipelined reads, slave withholds ACK -> o_mstb accepted 3 times, then o_sstall[g]=1. One ACK -> 4th request accepted the next cycle. The 5 ACKs total reach only o_sack[g], with data on o_sdata.
- Owner mid-burst, i_merr with outstanding=2 -> o_serr[g]=1 for 1 cycle, o_mcyc=0 the next cycle, grant held until owner drops CYC, then IDLE; a late i_mack is not forwarded.
- TIMEOUT=8, 1 outstanding, no ACK -> o_serr[g] asserted in the 9th cycle after acceptance, then ERRWAIT, then IDLE after owner drops CYC.
- i_reset pulsed asynchronously while OWNED with outstanding=3 -> o_mcyc, o_grant, o_sack drop immediately without waiting for a clock edge. After release, requester 0 has priority again.
